// File: rtl/spi_ahb_loader.sv
// rtl/spi_ahb_loader.sv - SPI slave (mode 0) to AHB-Lite single-beat master loader bridge
module spi_ahb_loader #(
    parameter int CLK_PER_SCLK_MIN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        SPI_change,
    output logic [31:0] spi_haddr,
    output logic [31:0] spi_hwdata,
    output logic [1:0]  spi_htrans,
    output logic        spi_hwrite,
    output logic [2:0]  spi_hsize,
    output logic [2:0]  spi_hburst,
    output logic [3:0]  spi_hprot,
    output logic        spi_hmastlock,
    input  logic [31:0] spi_hrdata,
    input  logic        spi_hready,
    input  logic        spi_hresp,
    output logic        err
);
    if (CLK_PER_SCLK_MIN < 4) begin : g_sclk_ratio_check
        $error("CLK_PER_SCLK_MIN too small for synchronizer latency");
    end

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h05;

    typedef enum logic [2:0] {
        F_IDLE, F_CMD, F_ADDR, F_WDATA, F_RDUMMY, F_RDATA, F_STAT, F_IGNORE
    } f_state_t;
    typedef enum logic [1:0] {A_IDLE, A_ADDR, A_DATA} a_state_t;

    f_state_t f_state, f_next;
    a_state_t a_state, a_next;

    logic [1:0]  sclk_sync, cs_sync, mosi_sync;
    logic        sclk_d, cs_d;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [31:0] sr, shift_in, osr, rbuf, wbuf, a_addr;
    logic [7:0]  cmd;
    logic [4:0]  bit_cnt, out_cnt;
    logic        req, ovr, busy, issue, xfer_done;
    logic        cmd_done, addr_done, word_done, dummy_done, stat_done, pf_issue;

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign cs_rise   = cs_sync[1] & ~cs_d;
    assign cs_fall   = ~cs_sync[1] & cs_d;
    assign shift_in  = {sr[30:0], mosi_sync[1]};

    assign busy      = req || (a_state != A_IDLE);
    // cs_sync[1] high means the frame has ended: nothing new may start.
    assign issue     = (a_state == A_IDLE) && req && !cs_sync[1];
    assign xfer_done = (a_state == A_DATA) && spi_hready;

    assign spi_htrans    = (a_state == A_ADDR) ? 2'b10 : 2'b00;
    assign spi_haddr     = a_addr;
    assign spi_hwdata    = wbuf;
    assign spi_hsize     = 3'b010;
    assign spi_hburst    = 3'b000;
    assign spi_hprot     = 4'b0011;
    assign spi_hmastlock = 1'b0;

    always_comb begin
        f_next     = f_state;
        cmd_done   = 1'b0;
        addr_done  = 1'b0;
        word_done  = 1'b0;
        dummy_done = 1'b0;
        stat_done  = 1'b0;
        if (cs_rise) begin
            f_next = F_IDLE;
        end else if (cs_fall) begin
            f_next = F_CMD;
        end else if (sclk_rise) begin
            case (f_state)
                F_CMD: if (bit_cnt == 5'd7) begin
                    cmd_done = 1'b1;
                    if (shift_in[7:0] == CMD_WRITE || shift_in[7:0] == CMD_READ ||
                        shift_in[7:0] == CMD_STATUS)
                        f_next = F_ADDR;
                    else
                        f_next = F_IGNORE;
                end
                F_ADDR: if (bit_cnt == 5'd31) begin
                    addr_done = 1'b1;
                    if (cmd == CMD_WRITE)     f_next = F_WDATA;
                    else if (cmd == CMD_READ) f_next = F_RDUMMY;
                    else                      f_next = F_STAT;
                end
                F_WDATA:  word_done = (bit_cnt == 5'd31);
                F_RDUMMY: if (bit_cnt == 5'd7) begin
                    dummy_done = 1'b1;
                    f_next     = F_RDATA;
                end
                F_STAT: if (bit_cnt == 5'd7) begin
                    stat_done = 1'b1;
                    f_next    = F_IGNORE;
                end
                default: ;
            endcase
        end
    end

    // Prefetch the next word once the last bit of the current one is on MISO.
    assign pf_issue = sclk_fall && !cs_rise && !cs_fall && (f_state == F_RDATA) &&
                      (out_cnt == 5'd31);

    always_comb begin
        a_next = a_state;
        case (a_state)
            A_IDLE: if (issue) a_next = A_ADDR;
            A_ADDR: a_next = A_DATA;
            A_DATA: if (spi_hready) a_next = A_IDLE;
            default: a_next = A_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            f_state   <= F_IDLE;
            a_state   <= A_IDLE;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
            f_state   <= f_next;
            a_state   <= a_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr         <= '0;
            osr        <= '0;
            rbuf       <= '0;
            wbuf       <= '0;
            a_addr     <= '0;
            cmd        <= '0;
            bit_cnt    <= '0;
            out_cnt    <= '0;
            req        <= 1'b0;
            ovr        <= 1'b0;
            err        <= 1'b0;
            miso       <= 1'b0;
            spi_hwrite <= 1'b0;
            SPI_change <= 1'b0;
        end else begin
            if (sclk_rise)
                sr <= shift_in;
            if (cs_rise || cs_fall)
                bit_cnt <= '0;
            else if (sclk_rise)
                bit_cnt <= (cmd_done || addr_done || dummy_done) ? 5'd0 : bit_cnt + 5'd1;
            if (cmd_done)
                cmd <= shift_in[7:0];

            if (addr_done)
                a_addr <= shift_in;
            else if (xfer_done)
                a_addr <= a_addr + 32'd4;

            if (xfer_done && !spi_hwrite)
                rbuf <= spi_hrdata;

            if (stat_done) begin
                err <= 1'b0;
                ovr <= 1'b0;
            end
            if (xfer_done && spi_hresp)
                err <= 1'b1;

            if (cs_rise) begin
                req <= 1'b0;
            end else begin
                if (issue)
                    req <= 1'b0;
                if (addr_done && cmd == CMD_READ) begin
                    req        <= 1'b1;
                    spi_hwrite <= 1'b0;
                end
                if (word_done) begin
                    if (busy) begin
                        ovr <= 1'b1;
                    end else begin
                        req        <= 1'b1;
                        spi_hwrite <= 1'b1;
                        wbuf       <= shift_in;
                    end
                end
                if (pf_issue && !busy) begin
                    req        <= 1'b1;
                    spi_hwrite <= 1'b0;
                end
            end

            if (addr_done && cmd == CMD_STATUS)
                osr <= {6'b0, ovr, err, 24'h0};

            if (cs_rise || cs_fall) begin
                miso    <= 1'b0;
                out_cnt <= '0;
            end else if (sclk_fall) begin
                case (f_state)
                    F_RDATA: begin
                        if (out_cnt == 5'd0) begin
                            miso <= rbuf[31];
                            osr  <= {rbuf[30:0], 1'b0};
                        end else begin
                            miso <= osr[31];
                            osr  <= {osr[30:0], 1'b0};
                        end
                        out_cnt <= out_cnt + 5'd1;
                    end
                    F_STAT: begin
                        miso <= osr[31];
                        osr  <= {osr[30:0], 1'b0};
                    end
                    default: miso <= 1'b0;
                endcase
            end

            if (cs_fall)
                SPI_change <= 1'b1;
            else if (cs_sync[1] && a_state == A_IDLE && !req)
                SPI_change <= 1'b0;
        end
    end
endmodule
